uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one UART transmitter among NUM_REQ requesters (protocol engines, status reporters, loopback echo).
Grants the transmitter per packet. The grant is held from the first accepted word until a word marked last completes.
Words are DATA_W wide, matching the 9-bit frame used by the receiver.
Sits between the requesters and the transmitter, with a watchdog so a hung transmitter or a stalled requester cannot lock the link.

---
 rtl/uart_tx_sched.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_sched
//  Purpose  : Round-robin packet scheduler sharing one UART transmitter among
//             NUM_REQ requesters. A grant is taken on the first word of a
//             packet and held until the word flagged last has been sent. A
//             watchdog releases the link if the transmitter never reports
//             tx_done or the owning requester stops supplying words.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             req_valid/req_data/req_last/req_ready - per-requester word
//                                   handshake (requester i at
//                                   req_data[i*DATA_W +: DATA_W])
//             tx_start/tx_data    - start pulse and word to the transmitter
//             tx_busy/tx_done     - transmitter status / frame-complete pulse
//             grant_active/grant_id - current owner of the transmitter
//             timeout_err         - one-cycle pulse on watchdog expiry
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 9,
    parameter int TIMEOUT = 131072,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        tx_start,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_busy,
    input  logic                        tx_done,
    output logic                        grant_active,
    output logic [ID_W-1:0]             grant_id,
    output logic                        timeout_err
);

    localparam int c_WD_W = $clog2(TIMEOUT + 1);
    localparam logic [c_WD_W-1:0] c_WD_MAX  = '1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SEND = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;

    logic [1:0]          r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_gid;
    logic                r_grant;
    logic                r_last;
    logic                r_tx_start;
    logic [DATA_W-1:0]   r_tx_data;
    logic                r_timeout;
    logic [c_WD_W-1:0]   r_wd;

    logic                w_found;
    logic [ID_W-1:0]     w_pick;
    logic [ID_W-1:0]     w_cand;
    logic [NUM_REQ-1:0]  w_ready;
    logic                w_accept;
    logic [DATA_W-1:0]   w_sel;
    logic [c_WD_W-1:0]   w_wd_inc;
    logic                w_expire;

    // Requester index (v + step) wrapped into 0..NUM_REQ-1; NUM_REQ need not
    // be a power of two.
    function automatic logic [ID_W-1:0] f_wrap(input logic [ID_W-1:0] v, input int step);
        return ID_W'((int'(v) + step) % NUM_REQ);
    endfunction

    // First valid requester searching from the round-robin pointer upward.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = f_wrap(r_ptr, k);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // Only the owner sees ready, and only while the transmitter is free.
    always_comb begin
        w_ready = '0;
        if (r_state == c_SEND) begin
            w_ready[r_gid] = !tx_busy;
        end
    end

    assign w_accept = (r_state == c_SEND) && !tx_busy && req_valid[r_gid];
    assign w_sel    = req_data[int'(r_gid)*DATA_W +: DATA_W];

    // Saturating increment; expiry fires on the edge where the count would
    // step onto TIMEOUT-1, so the pulse lands TIMEOUT cycles after the
    // counter was last cleared.
    assign w_wd_inc = (r_wd == c_WD_MAX) ? r_wd : r_wd + c_WD_W'(1);
    assign w_expire = (w_wd_inc == c_WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_ptr      <= '0;
            r_gid      <= '0;
            r_grant    <= 1'b0;
            r_last     <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_timeout  <= 1'b0;
            r_wd       <= '0;
        end else begin
            r_tx_start <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_wd <= '0;
                    if (w_found) begin
                        r_gid   <= w_pick;
                        r_grant <= 1'b1;
                        r_state <= c_SEND;
                    end
                end
                c_SEND: begin
                    if (w_accept) begin
                        r_tx_data  <= w_sel;
                        r_tx_start <= 1'b1;
                        r_last     <= req_last[r_gid];
                        r_wd       <= '0;
                        r_state    <= c_WAIT;
                    end else if (w_expire) begin
                        r_timeout <= 1'b1;
                        r_grant   <= 1'b0;
                        r_ptr     <= f_wrap(r_gid, 1);
                        r_wd      <= '0;
                        r_state   <= c_IDLE;
                    end else begin
                        r_wd <= w_wd_inc;
                    end
                end
                c_WAIT: begin
                    // A completed frame takes priority over a coincident expiry.
                    if (tx_done) begin
                        r_wd <= '0;
                        if (r_last) begin
                            r_grant <= 1'b0;
                            r_ptr   <= f_wrap(r_gid, 1);
                            r_state <= c_IDLE;
                        end else begin
                            r_state <= c_SEND;
                        end
                    end else if (w_expire) begin
                        r_timeout <= 1'b1;
                        r_grant   <= 1'b0;
                        r_ptr     <= f_wrap(r_gid, 1);
                        r_wd      <= '0;
                        r_state   <= c_IDLE;
                    end else begin
                        r_wd <= w_wd_inc;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_grant <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = w_ready;
    assign tx_start     = r_tx_start;
    assign tx_data      = r_tx_data;
    assign grant_active = r_grant;
    assign grant_id     = r_gid;
    assign timeout_err  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_sched
//  Purpose  : Self-checking bench for uart_tx_sched: directed timing steps
//             followed by random packet traffic compared against a
//             round-robin packet-order model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 9;
    localparam int TIMEOUT = 16;
    localparam int ID_W    = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_last;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       tx_start;
    logic [DATA_W-1:0]          tx_data;
    logic                       tx_busy;
    logic                       tx_done;
    logic                       grant_active;
    logic [ID_W-1:0]            grant_id;
    logic                       timeout_err;

    uart_tx_sched #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .ID_W    (ID_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .grant_active (grant_active),
        .grant_id     (grant_id),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // random-phase state
    logic [DATA_W:0]  wq [NUM_REQ][16];   // {last, data}
    int               cnt [NUM_REQ];
    int               pos [NUM_REQ];
    int               pm  [NUM_REQ];
    int               gap [NUM_REQ];
    logic [DATA_W-1:0] exp_w  [64];
    int               exp_id [64];
    int               n_exp, n_got, mptr, pick, jj, busy_cnt, err_cnt, npk, len;
    logic             done_pk, was_last;
    logic [NUM_REQ-1:0] rdy_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int id, input logic [DATA_W-1:0] d);
        req_data[id*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0; req_data = '0; req_last = '0;
        tx_busy = 1'b0; tx_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Present one word from requester id, wait (bounded) for acceptance,
    // check the resulting frame start, then complete it with tx_done.
    task automatic frame(input string tag, input int id, input logic [DATA_W-1:0] d,
                         input logic last, input logic keep);
        logic found;
        found = 1'b0;
        req_valid[id] = 1'b1;
        set_data(id, d);
        req_last[id] = last;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (req_ready[id] && req_valid[id]) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_rdy"}, 32'(found), 1);
        tick();
        req_valid[id] = keep;
        @(negedge clk);
        chk({tag, "_start"}, 32'(tx_start), 1);
        chk({tag, "_data"}, 32'(tx_data), 32'(d));
        chk({tag, "_id"}, 32'(grant_id), 32'(id));
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic apply_req();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pos[i] < cnt[i] && gap[i] == 0) begin
                req_valid[i] = 1'b1;
                req_data[i*DATA_W +: DATA_W] = wq[i][pos[i]][DATA_W-1:0];
                req_last[i] = wq[i][pos[i]][DATA_W];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    initial begin
        int e;
        // ---------------- reset state ----------------
        rst = 1'b1;
        req_valid = '0; req_data = '0; req_last = '0;
        tx_busy = 1'b0; tx_done = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst_ga",    32'(grant_active), 0);
        chk("rst_gid",   32'(grant_id), 0);
        chk("rst_start", 32'(tx_start), 0);
        chk("rst_data",  32'(tx_data), 0);
        chk("rst_rdy",   32'(req_ready), 0);
        chk("rst_err",   32'(timeout_err), 0);
        tick();
        rst = 1'b0;

        // ---------------- single requester timing ----------------
        req_valid = 4'b0010; set_data(1, 9'h1A5); req_last = 4'b0010;
        @(negedge clk);
        chk("s_c0_ga", 32'(grant_active), 0);
        tick();
        @(negedge clk);
        chk("s_c1_ga",  32'(grant_active), 1);
        chk("s_c1_id",  32'(grant_id), 1);
        chk("s_c1_rdy", 32'(req_ready), 'b0010);
        chk("s_c1_st",  32'(tx_start), 0);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("s_c2_st",   32'(tx_start), 1);
        chk("s_c2_data", 32'(tx_data), 'h1A5);
        chk("s_c2_rdy",  32'(req_ready), 0);
        tick();
        tx_busy = 1'b1;
        @(negedge clk);
        chk("s_c3_st",   32'(tx_start), 0);
        chk("s_c3_data", 32'(tx_data), 'h1A5);
        tick();
        tx_busy = 1'b0; tx_done = 1'b1;
        @(negedge clk);
        chk("s_c4_ga", 32'(grant_active), 1);
        tick();
        tx_done = 1'b0;
        @(negedge clk);
        chk("s_rel_ga", 32'(grant_active), 0);

        // ---------------- packet hold (pointer now 2) ----------------
        req_valid = 4'b0111; req_last = 4'b0011;
        set_data(0, 9'h0F0); set_data(1, 9'h0E1);
        frame("ph0", 2, 9'h011, 1'b0, 1'b1);
        frame("ph1", 2, 9'h022, 1'b0, 1'b1);
        frame("ph2", 2, 9'h133, 1'b1, 1'b0);
        frame("ph3", 0, 9'h0F0, 1'b1, 1'b0);

        // ---------------- round robin fairness ----------------
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 9'(9'h100 + i * 9'h011));
        req_last = 4'b1111; req_valid = 4'b1111;
        frame("rr0", 0, 9'h100, 1'b1, 1'b1);
        frame("rr1", 1, 9'h111, 1'b1, 1'b1);
        frame("rr2", 2, 9'h122, 1'b1, 1'b1);
        frame("rr3", 3, 9'h133, 1'b1, 1'b1);
        frame("rr4", 0, 9'h100, 1'b1, 1'b1);

        // ---------------- busy back-pressure (pointer now 1) ----------------
        req_valid = 4'b1000; set_data(3, 9'h1C3); req_last = 4'b1000; tx_busy = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("bp_ga",   32'(grant_active), 1);
        chk("bp_id",   32'(grant_id), 3);
        chk("bp_rdy0", 32'(req_ready), 0);
        chk("bp_st0",  32'(tx_start), 0);
        tick();
        @(negedge clk);
        chk("bp_rdy1", 32'(req_ready), 0);
        chk("bp_st1",  32'(tx_start), 0);
        tick();
        tx_busy = 1'b0;
        @(negedge clk);
        chk("bp_rdy2", 32'(req_ready), 'b1000);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("bp_st2",   32'(tx_start), 1);
        chk("bp_data2", 32'(tx_data), 'h1C3);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;

        // ---------------- watchdog ----------------
        do_reset();
        req_valid = 4'b0010; req_last = 4'b0111;
        set_data(0, 9'h055); set_data(1, 9'h0AA); set_data(2, 9'h0CC);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("wd_rdy", 32'(req_ready), 'b0010);       // accept cycle A
        tick();
        req_valid = 4'b0111;
        e = 0;
        @(negedge clk);
        chk("wd_start", 32'(tx_start), 1);
        if (timeout_err) e++;
        tick();
        for (int k = 2; k <= 15; k++) begin
            @(negedge clk);
            if (timeout_err) e++;
            tick();
        end
        chk("wd_early", 32'(e), 0);
        @(negedge clk);                              // A+16
        chk("wd_err",    32'(timeout_err), 1);
        chk("wd_rel_ga", 32'(grant_active), 0);
        tick();
        @(negedge clk);                              // A+17, accept cycle B
        chk("wd_err_off", 32'(timeout_err), 0);
        chk("wd_next_ga", 32'(grant_active), 1);
        chk("wd_next_id", 32'(grant_id), 2);
        chk("wd_next_rdy", 32'(req_ready), 'b0100);
        tick();
        req_valid = 4'b0011;
        @(negedge clk);
        chk("co_start", 32'(tx_start), 1);
        chk("co_data",  32'(tx_data), 'h0CC);
        tick();
        repeat (13) tick();                          // B+15
        tx_done = 1'b1;
        @(negedge clk);
        chk("co_err15", 32'(timeout_err), 0);
        tick();
        tx_done = 1'b0;
        @(negedge clk);
        chk("co_err16", 32'(timeout_err), 0);
        chk("co_ga16",  32'(grant_active), 0);
        tick();
        @(negedge clk);
        chk("co_err17", 32'(timeout_err), 0);
        chk("co_ga17",  32'(grant_active), 1);
        chk("co_id17",  32'(grant_id), 0);

        // ---------------- reset mid-WAIT ----------------
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("rw_start", 32'(tx_start), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; tx_done = 1'b1;
        @(negedge clk);
        chk("rw_ga",   32'(grant_active), 0);
        chk("rw_gid",  32'(grant_id), 0);
        chk("rw_data", 32'(tx_data), 0);
        chk("rw_st",   32'(tx_start), 0);
        chk("rw_rdy",  32'(req_ready), 0);
        chk("rw_err",  32'(timeout_err), 0);
        tick();
        tx_done = 1'b0;
        @(negedge clk);
        chk("rw_late_ga", 32'(grant_active), 0);
        chk("rw_late_st", 32'(tx_start), 0);
        tick();
        @(negedge clk);
        chk("rw_late_st2", 32'(tx_start), 0);

        // ---------------- random packets vs round-robin model ----------------
        for (int round = 0; round < 4; round++) begin
            do_reset();
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt[i] = 0; pos[i] = 0; pm[i] = 0; gap[i] = 0;
                npk = int'($urandom_range(0, 3));
                for (int p = 0; p < npk; p++) begin
                    len = int'($urandom_range(1, 3));
                    for (int w = 0; w < len; w++) begin
                        wq[i][cnt[i]] = {(w == len - 1), 9'($urandom)};
                        cnt[i]++;
                    end
                end
            end
            // Whole packets in round-robin order among requesters with work left.
            mptr = 0; n_exp = 0;
            for (int g = 0; g < 16; g++) begin
                pick = -1;
                for (int k = 0; k < NUM_REQ; k++) begin
                    jj = (mptr + k) % NUM_REQ;
                    if (pick < 0 && pm[jj] < cnt[jj]) pick = jj;
                end
                if (pick >= 0) begin
                    done_pk = 1'b0;
                    while (!done_pk) begin
                        exp_w[n_exp]  = wq[pick][pm[pick]][DATA_W-1:0];
                        exp_id[n_exp] = pick;
                        done_pk = wq[pick][pm[pick]][DATA_W];
                        pm[pick]++;
                        n_exp++;
                    end
                    mptr = (pick + 1) % NUM_REQ;
                end
            end
            n_got = 0; busy_cnt = 0; err_cnt = 0;
            apply_req();
            for (int c = 0; c < 3000 && n_got < n_exp; c++) begin
                @(negedge clk);
                rdy_s = req_ready & req_valid;
                if (timeout_err) err_cnt++;
                if (tx_start) begin
                    chk("rnd_data", 32'(tx_data), 32'(exp_w[n_got]));
                    chk("rnd_id",   32'(grant_id), 32'(exp_id[n_got]));
                    n_got++;
                    busy_cnt = int'($urandom_range(1, 4));
                end
                tick();
                tx_done = 1'b0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (gap[i] > 0) gap[i]--;
                    if (rdy_s[i]) begin
                        was_last = wq[i][pos[i]][DATA_W];
                        pos[i]++;
                        if (!was_last) gap[i] = int'($urandom_range(0, 3));
                    end
                end
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) begin
                        tx_done = 1'b1;
                        tx_busy = 1'b0;
                    end else begin
                        tx_busy = 1'b1;
                    end
                end
                apply_req();
            end
            chk("rnd_count", 32'(n_got), 32'(n_exp));
            chk("rnd_noerr", 32'(err_cnt), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete in time");
        $fatal(1, "bench time limit reached");
    end

endmodule
`default_nettype wire
